memory_reader: RTL and testbench
================================

Name: memory_reader

Overview:
- Sequential reader for a synchronous single-port byte RAM, the read-side counterpart of the memory initialiser that fills that RAM.
- On `start`, walks addresses 0..DEPTH-1, fetches each byte and presents it on a valid/ready byte stream.
- Accumulates a mod-2^DATA_WIDTH checksum for bench and system self-check.
- Sits between the RAM read port and any byte consumer (LEDs, UART, checker).

Parameters:
- ADDR_WIDTH, 8, RAM address width.
- DATA_WIDTH, 8, RAM word / stream width.
- DEPTH, 256, words read per pass. Legal range 1..2^ADDR_WIDTH.
- READ_LATENCY, 1, cycles from the `ram_rd_en` cycle to valid `ram_rdata`. Legal range 1..4.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a pass; sampled only in IDLE.
- ram_addr  out  ADDR_WIDTH  RAM read address.
- ram_rd_en  out  1  RAM read strobe.
- ram_rdata  in  DATA_WIDTH  RAM read data, valid READ_LATENCY cycles after `ram_rd_en`.
- out  out  DATA_WIDTH  stream byte.
- out_valid  out  1  `out` holds a byte.
- out_ready  in  1  consumer accepts the byte.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse at end of pass.
- checksum  out  DATA_WIDTH  sum of bytes accepted this pass, mod 2^DATA_WIDTH.

Behaviour:
- All outputs are registered. Reset is synchronous, active-high, and wins over every other input.
- Reset values: `ram_addr`=0, `ram_rd_en`=0, `out`=0, `out_valid`=0, `busy`=0, `done`=0, `checksum`=0, state=IDLE, `ptr`=0, latency counter=0.
- FSM states: IDLE, REQ, WAIT, HOLD, DONE.
- IDLE:
  - `start`=1 → `ptr`<=0, `checksum`<=0, `busy`<=1, go to REQ.
  - `start` is ignored in every other state.
- REQ (one cycle): `ram_rd_en`=1 and `ram_addr`=`ptr` in this cycle. Go to WAIT with the latency counter loaded to READ_LATENCY.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle where `ram_rdata` is valid (the READ_LATENCY-th cycle after REQ), capture `out`<=`ram_rdata`, set `out_valid`<=1, go to HOLD.
  - `ram_rd_en`=0 throughout WAIT.
- HOLD:
  - `out` and `out_valid` stay stable until `out_ready`=1. No change while `out_ready`=0, for any duration.
  - On handshake (`out_valid`&`out_ready`): `checksum`<=`checksum`+`out` (truncated), `out_valid`<=0.
  - If `ptr`==DEPTH-1, go to DONE; else `ptr`<=`ptr`+1 and go to REQ.
- DONE (one cycle): `done`=1, `busy`=0 from the next cycle, return to IDLE. `checksum` and `out` hold until the next accepted `start`.
- Latency with READ_LATENCY=1 and `out_ready` held 1:
  - `start` sampled at cycle 0 → REQ at cycle 1 → WAIT at cycle 2 → `out_valid` at cycle 3.
  - 3 cycles per byte.
  - `done` is high in the cycle after the last handshake.
  - General per-byte period: 2+READ_LATENCY cycles.
- `ptr` never wraps within a pass. DEPTH=2^ADDR_WIDTH ends at the all-ones address.
- DEPTH=1: single REQ/WAIT/HOLD, then DONE.
- Reset mid-pass: returns to IDLE immediately. Any in-flight byte is dropped and `checksum` is cleared.
- `start` held high through DONE: IDLE re-samples it on the cycle after DONE, so a new pass begins. Back-to-back passes are legal.
- `out_ready` high outside HOLD has no effect.

Test Plan:
- RAM model mem[i]=i, DEPTH=4, READ_LATENCY=1, `out_ready`=1, pulse `start` → bytes 0,1,2,3 each 3 cycles apart; first `out_valid` 3 cycles after `start`; `done` pulse once; `checksum`=8'h06; `busy` high from cycle 1 until `done`.
- Same setup, `out_ready` low for 5 cycles while the byte 2 is presented → `out` stays 8'h02 with `out_valid`=1 all 5 cycles; no address advance; sequence and `checksum` (8'h06) unchanged.
- DEPTH=256, mem[i]=i, `out_ready` toggling every cycle → 256 bytes 0..255 in order; `checksum`=8'h80; last address 8'hFF; no wrap.
- READ_LATENCY=3, mem[i]=8'hA5^i, DEPTH=2 → `ram_rd_en` pulses 5 cycles apart; bytes 8'hA5, 8'hA4; `checksum`=8'h49.
- Assert `reset` one cycle while HOLD on byte 1 → next cycle all outputs are at reset values; a following `start` restarts at address 0 with `checksum` from 0.
- Pulse `start` again while `busy`=1 → ignored; exactly DEPTH bytes and a single `done` for the pass.

Source files
------------

// File: rtl/memory_reader.sv
// Sequential byte-RAM reader: on start, fetches addresses 0..DEPTH-1 and streams each
// byte over valid/ready while summing accepted bytes into a truncated checksum.
module memory_reader #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_rd_en,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam int CW = 3;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DONE} state_t;

  state_t                  state, n_state;
  logic [ADDR_WIDTH-1:0]   ptr, n_ptr, n_addr;
  logic [CW-1:0]           cnt, n_cnt;
  logic [DATA_WIDTH-1:0]   n_out, n_checksum;
  logic                    n_valid, n_rd_en, n_busy, n_done;

  // Every output is computed one cycle ahead so it can leave a flop.
  always_comb begin
    n_state    = state;
    n_ptr      = ptr;
    n_addr     = ram_addr;
    n_cnt      = cnt;
    n_out      = out;
    n_valid    = out_valid;
    n_checksum = checksum;
    n_busy     = busy;
    n_rd_en    = 1'b0;
    n_done     = 1'b0;
    case (state)
      IDLE: if (start) begin
        n_ptr      = '0;
        n_addr     = '0;
        n_checksum = '0;
        n_busy     = 1'b1;
        n_rd_en    = 1'b1;
        n_state    = REQ;
      end
      REQ: begin
        n_cnt   = CW'(READ_LATENCY);
        n_state = WAIT;
      end
      WAIT: begin
        if (cnt == CW'(1)) begin
          n_out   = ram_rdata;
          n_valid = 1'b1;
          n_state = HOLD;
        end else begin
          n_cnt = cnt - CW'(1);
        end
      end
      HOLD: if (out_ready) begin
        n_checksum = checksum + out;
        n_valid    = 1'b0;
        if (ptr == LAST) begin
          n_done  = 1'b1;
          n_state = DONE;
        end else begin
          n_ptr   = ptr + ADDR_WIDTH'(1);
          n_addr  = ptr + ADDR_WIDTH'(1);
          n_rd_en = 1'b1;
          n_state = REQ;
        end
      end
      DONE: begin
        n_busy  = 1'b0;
        n_state = IDLE;
      end
      default: n_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      ram_addr  <= '0;
      ram_rd_en <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      checksum  <= '0;
    end else begin
      state     <= n_state;
      ptr       <= n_ptr;
      cnt       <= n_cnt;
      ram_addr  <= n_addr;
      ram_rd_en <= n_rd_en;
      out       <= n_out;
      out_valid <= n_valid;
      busy      <= n_busy;
      done      <= n_done;
      checksum  <= n_checksum;
    end
  end

endmodule

// File: tb/tb_memory_reader.sv
// Directed bench for memory_reader: three configurations, each with its own RAM model
// and a byte scoreboard that is filled at start and drained on every handshake.
module tb_memory_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int checks = 0, errors = 0;

  // a: DEPTH=4, RL=1   b: DEPTH=256, RL=1   c: DEPTH=2, RL=3
  logic start_a, rdy_a, rd_a, vld_a, busy_a, done_a;
  logic start_b, rdy_b, rd_b, vld_b, busy_b, done_b;
  logic start_c, rdy_c, rd_c, vld_c, busy_c, done_c;
  logic [7:0] addr_a, rdata_a, out_a, ck_a;
  logic [7:0] addr_b, rdata_b, out_b, ck_b;
  logic [7:0] addr_c, rdata_c, out_c, ck_c;
  logic [7:0] c1, c2;

  logic [7:0] qa[$], qb[$], qc[$];
  int done_cnt_a = 0;

  memory_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(4), .READ_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .ram_addr(addr_a), .ram_rd_en(rd_a),
    .ram_rdata(rdata_a), .out(out_a), .out_valid(vld_a), .out_ready(rdy_a),
    .busy(busy_a), .done(done_a), .checksum(ck_a));

  memory_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(256), .READ_LATENCY(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .ram_addr(addr_b), .ram_rd_en(rd_b),
    .ram_rdata(rdata_b), .out(out_b), .out_valid(vld_b), .out_ready(rdy_b),
    .busy(busy_b), .done(done_b), .checksum(ck_b));

  memory_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(2), .READ_LATENCY(3)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .ram_addr(addr_c), .ram_rd_en(rd_c),
    .ram_rdata(rdata_c), .out(out_c), .out_valid(vld_c), .out_ready(rdy_c),
    .busy(busy_c), .done(done_c), .checksum(ck_c));

  // RAM models; 8'h5A marks data returned for a cycle with no read strobe.
  always @(posedge clk) rdata_a <= rd_a ? addr_a : 8'h5A;
  always @(posedge clk) rdata_b <= rd_b ? addr_b : 8'h5A;
  always @(posedge clk) begin
    c1      <= rd_c ? (8'hA5 ^ addr_c) : 8'h5A;
    c2      <= c1;
    rdata_c <= c2;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors sample mid-cycle, ahead of the edge that completes a handshake.
  logic pst_a = 1'b0, pst_b = 1'b0;
  logic [7:0] pout_a, paddr_a, pout_b, paddr_b;

  always @(negedge clk) begin
    if (pst_a) begin
      chk("a_hold_valid", vld_a, 1);
      chk("a_hold_out", out_a, pout_a);
      chk("a_hold_addr", addr_a, paddr_a);
    end
    if (vld_a && rdy_a && !reset) begin
      if (qa.size() == 0) chk("a_extra_byte", out_a, 32'h100);
      else chk("a_byte", out_a, qa.pop_front());
    end
    if (done_a) done_cnt_a++;
    pst_a   = vld_a && !rdy_a && !reset;
    pout_a  = out_a;
    paddr_a = addr_a;
  end

  always @(negedge clk) begin
    if (pst_b) begin
      chk("b_hold_valid", vld_b, 1);
      chk("b_hold_out", out_b, pout_b);
      chk("b_hold_addr", addr_b, paddr_b);
    end
    if (vld_b && rdy_b && !reset) begin
      if (qb.size() == 0) chk("b_extra_byte", out_b, 32'h100);
      else chk("b_byte", out_b, qb.pop_front());
    end
    pst_b   = vld_b && !rdy_b && !reset;
    pout_b  = out_b;
    paddr_b = addr_b;
  end

  always @(negedge clk) begin
    if (vld_c && rdy_c && !reset) begin
      if (qc.size() == 0) chk("c_extra_byte", out_c, 32'h100);
      else chk("c_byte", out_c, qc.pop_front());
    end
  end

  initial begin
    int n, d0, r1, r2;
    reset = 1'b1;
    start_a = 0; start_b = 0; start_c = 0;
    rdy_a = 0; rdy_b = 0; rdy_c = 0;
    repeat (3) step();
    chk("rst_addr", addr_a, 0);
    chk("rst_rd_en", rd_a, 0);
    chk("rst_out", out_a, 0);
    chk("rst_valid", vld_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_checksum", ck_a, 0);
    chk("rst_busy_c", busy_c, 0);
    reset = 1'b0;
    step();

    // basic pass, ready held high
    d0 = done_cnt_a;
    for (int i = 0; i < 4; i++) qa.push_back(8'(i));
    rdy_a = 1; start_a = 1;
    step();
    start_a = 0;
    chk("t1_busy_c1", busy_a, 1);
    chk("t1_rd_en_c1", rd_a, 1);
    chk("t1_addr_c1", addr_a, 0);
    step();
    chk("t1_valid_c2", vld_a, 0);
    step();
    chk("t1_valid_c3", vld_a, 1);
    chk("t1_out_c3", out_a, 0);
    n = 3;
    while (!done_a && n < 100) begin step(); n++; end
    chk("t1_done_cycle", n, 13);
    chk("t1_checksum", ck_a, 8'h06);
    chk("t1_busy_in_done", busy_a, 1);
    step();
    chk("t1_busy_after", busy_a, 0);
    chk("t1_done_pulse", done_a, 0);
    chk("t1_done_count", done_cnt_a - d0, 1);
    chk("t1_sb_empty", qa.size(), 0);

    // stall on byte 2 for five cycles
    d0 = done_cnt_a;
    for (int i = 0; i < 4; i++) qa.push_back(8'(i));
    start_a = 1;
    step();
    start_a = 0;
    n = 1;
    while (!(vld_a && out_a == 8'h02) && n < 100) begin step(); n++; end
    rdy_a = 0;
    chk("t2_byte2_valid", vld_a, 1);
    repeat (5) begin
      step();
      chk("t2_stall_valid", vld_a, 1);
      chk("t2_stall_out", out_a, 8'h02);
      chk("t2_stall_addr", addr_a, 8'h02);
    end
    rdy_a = 1;
    n = 0;
    while (!done_a && n < 100) begin step(); n++; end
    chk("t2_done", done_a, 1);
    chk("t2_checksum", ck_a, 8'h06);
    step();
    chk("t2_done_count", done_cnt_a - d0, 1);
    chk("t2_sb_empty", qa.size(), 0);

    // extra start pulses during a pass are ignored
    d0 = done_cnt_a;
    for (int i = 0; i < 4; i++) qa.push_back(8'(i));
    start_a = 1;
    step();
    start_a = 0;
    step(); step();
    start_a = 1; step(); start_a = 0;
    repeat (3) step();
    start_a = 1; step(); start_a = 0;
    n = 0;
    while (!done_a && n < 100) begin step(); n++; end
    chk("t6_done", done_a, 1);
    repeat (10) step();
    chk("t6_done_count", done_cnt_a - d0, 1);
    chk("t6_sb_empty", qa.size(), 0);
    chk("t6_idle", busy_a, 0);

    // reset while holding byte 1
    for (int i = 0; i < 4; i++) qa.push_back(8'(i));
    start_a = 1;
    step();
    start_a = 0;
    n = 1;
    while (!(vld_a && out_a == 8'h01) && n < 100) begin step(); n++; end
    chk("t5_byte1_valid", vld_a, 1);
    rdy_a = 0; reset = 1;
    step();
    reset = 0;
    chk("t5_addr", addr_a, 0);
    chk("t5_rd_en", rd_a, 0);
    chk("t5_out", out_a, 0);
    chk("t5_valid", vld_a, 0);
    chk("t5_busy", busy_a, 0);
    chk("t5_done", done_a, 0);
    chk("t5_checksum", ck_a, 0);
    qa.delete();
    step();
    chk("t5_still_idle", busy_a, 0);
    for (int i = 0; i < 4; i++) qa.push_back(8'(i));
    rdy_a = 1; start_a = 1;
    step();
    start_a = 0;
    chk("t5_restart_addr", addr_a, 0);
    chk("t5_restart_rd_en", rd_a, 1);
    n = 1;
    while (!done_a && n < 100) begin step(); n++; end
    chk("t5_done_cycle", n, 13);
    chk("t5_checksum", ck_a, 8'h06);
    step();
    chk("t5_sb_empty", qa.size(), 0);

    // full 256-byte pass with ready toggling every cycle
    for (int i = 0; i < 256; i++) qb.push_back(8'(i));
    start_b = 1;
    step();
    start_b = 0;
    n = 1;
    while (!done_b && n < 3000) begin rdy_b = ~rdy_b; step(); n++; end
    chk("t3_done", done_b, 1);
    chk("t3_checksum", ck_b, 8'h80);
    chk("t3_last_addr", addr_b, 8'hFF);
    chk("t3_sb_empty", qb.size(), 0);
    rdy_b = 0;

    // read latency 3
    qc.push_back(8'hA5); qc.push_back(8'hA4);
    rdy_c = 1; start_c = 1;
    step();
    start_c = 0;
    n = 1; r1 = -1; r2 = -1;
    while (!done_c && n < 100) begin
      if (rd_c) begin
        if (r1 < 0) r1 = n;
        else r2 = n;
      end
      step(); n++;
    end
    chk("t4_first_rd", r1, 1);
    chk("t4_rd_spacing", r2 - r1, 5);
    chk("t4_done_cycle", n, 11);
    chk("t4_checksum", ck_c, 8'h49);
    step();
    chk("t4_checksum_hold", ck_c, 8'h49);
    chk("t4_busy_after", busy_c, 0);
    chk("t4_sb_empty", qc.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
